// File: rtl/test_word_mem.sv
`default_nettype none
// ============================================================================
//  Module      : test_word_mem
//  Description : Word-wide 2**ADDR_W-deep test memory with independent write
//                and read addresses, a registered read port with valid flag,
//                and a hardware clear sequencer that sweeps every word to
//                INIT_VAL after reset or on clear_req.
//                Optional macro TEST_WORD_MEM_RDW_BYPASS_EN selects write-first
//                behaviour for a same-address read and write in one cycle;
//                when undefined the read returns the pre-write contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module test_word_mem #(
   parameter int               WIDTH    = 8,
   parameter int               ADDR_W   = 5,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              read_enable,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              clear_req,
   output logic [WIDTH-1:0]  data_out,
   output logic              rd_valid,
   output logic              busy
);

   localparam int                c_depth     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(c_depth - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [WIDTH-1:0]  w_mem_wdata;
   logic              w_rd_en;
   logic [WIDTH-1:0]  w_rd_data;

   logic [WIDTH-1:0]  r_mem [c_depth];
   logic [WIDTH-1:0]  r_data_out;
   logic              r_rd_valid;

   // Sweep state and clear counter; reset aborts any sweep and restarts at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic and the single shared write port (sweep or user write)
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mem_we    = 1'b0;
      w_mem_addr  = waddr;
      w_mem_wdata = data_in;
      w_rd_en     = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt;
            w_mem_wdata = INIT_VAL;
            if (r_cnt == c_last_addr) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            // A read alongside clear_req still happens and sees pre-clear data
            w_rd_en = read_enable;
            if (clear_req) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end else begin
               w_mem_we = write_enable;
            end
         end
         default: begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = '0;
         end
      endcase
   end

`ifdef TEST_WORD_MEM_RDW_BYPASS_EN
   // Write-first: a same-address user write forwards its data to the read
   assign w_rd_data = (w_mem_we && (r_state == ST_IDLE) && (waddr == raddr))
                      ? data_in : r_mem[raddr];
`else
   // Read-first: the array read sees contents before this edge's write
   assign w_rd_data = r_mem[raddr];
`endif

   // Storage array, no reset so it maps onto RAM; contents come from the sweep
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   // Registered read port; data_out holds between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_en;
         if (w_rd_en) begin
            r_data_out <= w_rd_data;
         end
      end
   end

   assign data_out = r_data_out;
   assign rd_valid = r_rd_valid;
   assign busy     = (r_state == ST_CLEAR);

endmodule
`default_nettype wire

// File: tb/tb_test_word_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_word_mem
//  Description : Self-checking bench for test_word_mem using a behavioural
//                memory model (array + remaining-sweep counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_word_mem;

   localparam int         WIDTH  = 8;
   localparam int         ADDR_W = 5;
   localparam int         DEPTH  = 32;
   localparam logic [7:0] INIT   = 8'h00;
`ifdef TEST_WORD_MEM_RDW_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              write_enable = 1'b0;
   logic [ADDR_W-1:0] waddr = '0;
   logic [WIDTH-1:0]  data_in = '0;
   logic              read_enable = 1'b0;
   logic [ADDR_W-1:0] raddr = '0;
   logic              clear_req = 1'b0;
   logic [WIDTH-1:0]  data_out;
   logic              rd_valid;
   logic              busy;

   // Reference model state
   logic [7:0] model [DEPTH];
   int         sweep_left;
   logic [7:0] exp_dout;
   logic       exp_valid;

   int errors = 0;
   int checks = 0;

   test_word_mem #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .INIT_VAL(INIT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_enable (write_enable),
      .waddr        (waddr),
      .data_in      (data_in),
      .read_enable  (read_enable),
      .raddr        (raddr),
      .clear_req    (clear_req),
      .data_out     (data_out),
      .rd_valid     (rd_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the model advances by the memory's rules
   task automatic step(input logic we, input logic [4:0] wa, input logic [7:0] din,
                       input logic re, input logic [4:0] ra, input logic clr);
      write_enable = we; waddr = wa; data_in = din;
      read_enable = re; raddr = ra; clear_req = clr;
      @(posedge clk);
      if (sweep_left > 0) begin
         exp_valid = 1'b0;
         sweep_left--;
         if (sweep_left == 0)
            for (int i = 0; i < DEPTH; i++) model[i] = INIT;
      end else begin
         if (re) begin
            exp_dout  = (BYPASS && we && !clr && wa == ra) ? din : model[ra];
            exp_valid = 1'b1;
         end else begin
            exp_valid = 1'b0;
         end
         if (we && !clr) model[wa] = din;
         if (clr) sweep_left = DEPTH;
      end
      #1;
      write_enable = 1'b0; read_enable = 1'b0; clear_req = 1'b0;
   endtask

   task automatic model_reset();
      sweep_left = DEPTH;
      exp_dout   = 8'h00;
      exp_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = INIT;
      #12;
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", data_out); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
   endtask

   task automatic test_sweep_len();
      int n;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && busy === 1'b1; i++) begin
         step(0, 0, 0, 0, 0, 0);
         n++;
         checks++; if (busy !== (sweep_left > 0)) begin errors++; $display("FAIL sweep_busy cyc=%0d got=%b exp=%b", n, busy, sweep_left > 0); end
      end
      checks++; if (n != DEPTH) begin errors++; $display("FAIL sweep_len got=%0d exp=%0d", n, DEPTH); end
      step(0, 0, 0, 1, 7, 0);
      checks++; if (data_out !== 8'h00 || rd_valid !== 1'b1) begin errors++; $display("FAIL first_read got=%h/%b exp=00/1", data_out, rd_valid); end
   endtask

   task automatic test_write_read();
      step(1, 3, 8'hA5, 0, 0, 0);
      step(0, 0, 0, 1, 3, 0);
      checks++; if (data_out !== 8'hA5 || rd_valid !== 1'b1) begin errors++; $display("FAIL wr_rd got=%h/%b exp=a5/1", data_out, rd_valid); end
      step(0, 0, 0, 0, 0, 0);
      checks++; if (data_out !== 8'hA5 || rd_valid !== 1'b0) begin errors++; $display("FAIL hold got=%h/%b exp=a5/0", data_out, rd_valid); end
   endtask

   task automatic test_rdw_same_addr();
      step(1, 10, 8'h11, 0, 0, 0);
      step(1, 10, 8'h22, 1, 10, 0);
      checks++; if (data_out !== (BYPASS ? 8'h22 : 8'h11)) begin errors++; $display("FAIL rdw got=%h exp=%h", data_out, BYPASS ? 8'h22 : 8'h11); end
      step(0, 0, 0, 1, 10, 0);
      checks++; if (data_out !== 8'h22 || rd_valid !== 1'b1) begin errors++; $display("FAIL rdw_after got=%h/%b exp=22/1", data_out, rd_valid); end
   endtask

   task automatic test_clear();
      logic [4:0] addrs [3];
      addrs[0] = 5'd31; addrs[1] = 5'd0; addrs[2] = 5'd5;
      step(1, 31, 8'hFF, 0, 0, 0);
      step(1, 0, 8'h5A, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      for (int i = 1; i <= DEPTH; i++) begin
         step(1, 5, 8'h77, 1, 5, 0);
         checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL clr_valid cyc=%0d got=%b exp=0", i, rd_valid); end
         checks++; if (busy !== (i < DEPTH)) begin errors++; $display("FAIL clr_busy cyc=%0d got=%b exp=%b", i, busy, i < DEPTH); end
      end
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 1, addrs[k], 0);
         checks++; if (data_out !== 8'h00 || rd_valid !== 1'b1) begin errors++; $display("FAIL clr_read addr=%0d got=%h/%b exp=00/1", addrs[k], data_out, rd_valid); end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      step(1, 2, 8'h5A, 0, 0, 0);
      step(0, 0, 0, 1, 2, 0);
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (data_out !== 8'h00 || rd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL async_rst got=%h/%b/%b exp=00/0/1", data_out, rd_valid, busy); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 40 && busy === 1'b1; i++) begin
         step(0, 0, 0, 0, 0, 0);
         n++;
      end
      checks++; if (n != DEPTH) begin errors++; $display("FAIL restart_len got=%0d exp=%0d", n, DEPTH); end
   endtask

   task automatic test_clear_vs_write();
      step(1, 4, 8'h99, 0, 0, 0);
      step(1, 4, 8'h3C, 1, 4, 1);
      checks++; if (data_out !== 8'h99 || rd_valid !== 1'b1) begin errors++; $display("FAIL clr_wr_read got=%h/%b exp=99/1", data_out, rd_valid); end
      for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_wr_busy got=%b exp=0", busy); end
      step(0, 0, 0, 1, 4, 0);
      checks++; if (data_out !== 8'h00 || rd_valid !== 1'b1) begin errors++; $display("FAIL clr_wr_drop got=%h/%b exp=00/1", data_out, rd_valid); end
   endtask

   task automatic test_random();
      logic       we, re, clr;
      logic [4:0] wa, ra;
      logic [7:0] din;
      for (int i = 0; i < 400; i++) begin
         we  = 1'($urandom_range(0, 1));
         re  = 1'($urandom_range(0, 1));
         ra  = 5'($urandom_range(0, 31));
         wa  = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 31));
         din = 8'($urandom);
         clr = ($urandom_range(0, 59) == 0);
         step(we, wa, din, re, ra, clr);
         checks++; if (busy !== (sweep_left > 0)) begin errors++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, sweep_left > 0); end
         checks++; if (rd_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, rd_valid, exp_valid); end
         checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL rnd_dout i=%0d got=%h exp=%h", i, data_out, exp_dout); end
      end
   endtask

   initial begin
      test_reset();
      test_sweep_len();
      test_write_read();
      test_rdw_same_addr();
      test_clear();
      test_reset_mid_sweep();
      test_clear_vs_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
